sap1_program_loader: RTL and testbench
======================================

Name: sap1_program_loader

Overview:
Programming-side initiator for the SAP-1 memory-address path. It accepts a stream of program words over a valid/ready handshake and drives the programmer address/data lines and the run/program select. It generates the active-low RAM write strobe and holds the CPU in clear while loading. When loading finishes it returns the address mux to run mode, so the MAR again drives RAM.

Parameters:
ADDR_WIDTH, 4, RAM address width; memory depth = 2**ADDR_WIDTH words
DATA_WIDTH, 8, RAM word width
WRITE_PULSE, 1, cycles WE_bar is held low per word (>=1)

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin loading at address 0
in_data  input  DATA_WIDTH  program word
in_valid  input  1  in_data valid
in_last  input  1  qualifies in_data as final word
in_ready  output  1  loader can accept a word this cycle
prog_address  output  ADDR_WIDTH  programmer address to the address mux
prog_data  output  DATA_WIDTH  word to RAM data inputs
run_or_prog  output  1  1 = run (MAR drives RAM); 0 = program (prog_address drives RAM)
WE_bar  output  1  active-low RAM write strobe
cpu_CLR  output  1  high holds CPU registers and PC in clear
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when loading completes
words_written  output  ADDR_WIDTH+1  words written in the current/last load

Behaviour:
- Reset values (at the CLK edge with CLR=1): state IDLE, run_or_prog=1, WE_bar=1, cpu_CLR=0, in_ready=0, busy=0, done=0, prog_address=0, prog_data=0, words_written=0.
- All outputs are registered, except in_ready, which is decoded from state (high only in WAIT).
- States: IDLE, WAIT, SETUP, WRITE, HOLD, FINISH.
- IDLE:
  - start=1 -> WAIT; prog_address=0, words_written=0, run_or_prog=0, cpu_CLR=1.
  - start is ignored in every state other than IDLE.
- WAIT:
  - in_ready=1.
  - in_valid=1 -> capture in_data into prog_data and in_last into a last flag; go to SETUP.
  - in_valid=0 -> stay in WAIT indefinitely.
- SETUP: one cycle; address and data stable, WE_bar=1 (address/data setup before the strobe).
- WRITE: WE_bar=0 for exactly WRITE_PULSE cycles (internal counter), then HOLD.
- HOLD:
  - One cycle with WE_bar=1 and address/data unchanged (hold time); words_written increments.
  - If the last flag is set, or prog_address == 2**ADDR_WIDTH-1, go to FINISH.
  - Otherwise prog_address increments and the state returns to WAIT.
- FINISH:
  - One cycle; done=1, run_or_prog=1, cpu_CLR stays 1 during this cycle.
  - Next state is IDLE, where cpu_CLR=0.
  - The CPU therefore leaves clear one cycle after the mux returns to run mode.
- Throughput: with WRITE_PULSE=1, 4 cycles per word from one accepted handshake to the next (WAIT, SETUP, WRITE, HOLD) with in_valid held high.
- Address wrap: the address never wraps. Filling the last address ends the load even if in_last=0. words_written then reads 2**ADDR_WIDTH (needs the extra bit).
- in_valid while in_ready=0: ignored; no word is consumed.
- in_last on the first word: exactly one word is written, then FINISH.
- WE_bar is never low in any cycle where prog_address or prog_data differs from the previous cycle.
- Reset mid-load:
  - At the next edge, return to reset values: WE_bar=1, run_or_prog=1, cpu_CLR=0.
  - A partial write can therefore truncate only at a clock edge, never glitch.
  - words_written is cleared.
- CLR has priority over start and the handshake in the same cycle.

Test Plan:
- Reset: hold CLR=1 for 2 cycles with start=1 -> run_or_prog=1, WE_bar=1, busy=0, cpu_CLR=0, in_ready=0.
- Short load: start; words 8'h1E@0, 8'h2F@1, 8'hF0@2 (in_last on the third), in_valid always high -> three WE_bar=0 pulses, each 1 cycle at addresses 0,1,2 with matching prog_data; done pulses once; words_written=3; run_or_prog=1 in FINISH; cpu_CLR falls one cycle later.
- Full memory: 16 words 8'h00..8'h0F, in_last never set -> writes at addresses 0..15, FINISH after address 15, words_written=16, no address wrap to 0.
- Stalled source: in_valid low for 5 cycles between words 1 and 2 -> loader stays in WAIT with in_ready=1 and WE_bar=1; address stays 1 until the word arrives; written data is correct.
- WRITE_PULSE=3 instance: one word 8'hA5 -> WE_bar low exactly 3 consecutive cycles; prog_address/prog_data stable from SETUP through HOLD.
- Reset mid-load: assert CLR during the WRITE of word 2 -> next edge WE_bar=1, run_or_prog=1, busy=0, words_written=0; start ignored while busy and accepted again after reset.

Source files
------------

// File: rtl/sap1_program_loader.sv
// SAP-1 program loader: streams words over valid/ready into RAM via the programmer mux.
// One word per WRITE_PULSE+3 cycles; in_ready only in WAIT, so the source is stalled everywhere else.
module sap1_program_loader #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int WRITE_PULSE = 1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] prog_address,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  run_or_prog,
  output logic                  WE_bar,
  output logic                  cpu_CLR,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_WRITE  = 3'd3,
    S_HOLD   = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  localparam int                  CW         = (WRITE_PULSE > 1) ? $clog2(WRITE_PULSE) : 1;
  localparam logic [CW-1:0]       PULSE_LAST = CW'(WRITE_PULSE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH:0]   ww_q, ww_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_bar_q, we_bar_d;
  logic                  rop_q, rop_d;
  logic                  cpu_clr_q, cpu_clr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // State register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_WAIT;
      S_WAIT:   if (in_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_WRITE;
      S_WRITE:  if (cnt_q == PULSE_LAST) state_d = S_HOLD;
      // The address never wraps: filling the top word ends the load on its own.
      S_HOLD:   state_d = (last_q || addr_q == ADDR_MAX) ? S_FINISH : S_WAIT;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; strobes are decoded from the next state
  // so every output is a flop aligned with the state it belongs to.
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    ww_d      = ww_q;
    cnt_d     = cnt_q;
    we_bar_d  = (state_d != S_WRITE);
    rop_d     = (state_d == S_IDLE) || (state_d == S_FINISH);
    cpu_clr_d = (state_d != S_IDLE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = '0;
          ww_d   = '0;
        end
      end
      S_WAIT: begin
        if (in_valid) begin
          data_d = in_data;
          last_d = in_last;
        end
      end
      S_SETUP: cnt_d = '0;
      S_WRITE: begin
        if (cnt_q == PULSE_LAST) begin
          ww_d = ww_q + 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (state_d == S_WAIT) addr_d = addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      ww_q      <= '0;
      cnt_q     <= '0;
      we_bar_q  <= 1'b1;
      rop_q     <= 1'b1;
      cpu_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      ww_q      <= ww_d;
      cnt_q     <= cnt_d;
      we_bar_q  <= we_bar_d;
      rop_q     <= rop_d;
      cpu_clr_q <= cpu_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign in_ready      = (state_q == S_WAIT);
  assign prog_address  = addr_q;
  assign prog_data     = data_q;
  assign run_or_prog   = rop_q;
  assign WE_bar        = we_bar_q;
  assign cpu_CLR       = cpu_clr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Directed bench for sap1_program_loader: vector table plus hand sequences.
module tb_sap1_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WRITE_PULSE=1 instance
  logic       clr, start, vld, last;
  logic [7:0] dat;
  logic       rdy, rop, we_bar, cpu_clr, busy, done;
  logic [3:0] addr;
  logic [7:0] pdat;
  logic [4:0] ww;

  // WRITE_PULSE=3 instance
  logic       clr3, start3, vld3, last3;
  logic [7:0] dat3;
  logic       rdy3, rop3, we_bar3, cpu_clr3, busy3, done3;
  logic [3:0] addr3;
  logic [7:0] pdat3;
  logic [4:0] ww3;

  sap1_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WRITE_PULSE(1)) u1 (
    .CLK(clk), .CLR(clr), .start(start), .in_data(dat), .in_valid(vld), .in_last(last),
    .in_ready(rdy), .prog_address(addr), .prog_data(pdat), .run_or_prog(rop),
    .WE_bar(we_bar), .cpu_CLR(cpu_clr), .busy(busy), .done(done), .words_written(ww));

  sap1_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WRITE_PULSE(3)) u3 (
    .CLK(clk), .CLR(clr3), .start(start3), .in_data(dat3), .in_valid(vld3), .in_last(last3),
    .in_ready(rdy3), .prog_address(addr3), .prog_data(pdat3), .run_or_prog(rop3),
    .WE_bar(we_bar3), .cpu_CLR(cpu_clr3), .busy(busy3), .done(done3), .words_written(ww3));

  typedef struct {
    logic       clr, start, vld, last;
    logic [7:0] dat;
    logic       we, rop, cpu, bsy, dn, rdy;
    logic [3:0] addr;
    logic [7:0] pdat;
    logic [4:0] ww;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic addv(input logic c, input logic s, input logic v, input logic [7:0] d, input logic l,
                      input logic we, input logic ro, input logic cp, input logic bs, input logic dn,
                      input logic rd, input logic [3:0] a, input logic [7:0] pd, input logic [4:0] w);
    vec_t t;
    t.clr = c; t.start = s; t.vld = v; t.dat = d; t.last = l;
    t.we = we; t.rop = ro; t.cpu = cp; t.bsy = bs; t.dn = dn; t.rdy = rd;
    t.addr = a; t.pdat = pd; t.ww = w;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1; start = 0; vld = 0; last = 0; dat = 0;
    clr3 = 1; start3 = 0; vld3 = 0; last3 = 0; dat3 = 0;

    //    clr st vld dat   lst | we rop cpu bsy dn rdy addr pdat  ww
    // reset with start held
    addv(1, 1, 0, 8'h00, 0,   1, 1, 0, 0, 0, 0, 4'd0, 8'h00, 5'd0);
    addv(1, 1, 0, 8'h00, 0,   1, 1, 0, 0, 0, 0, 4'd0, 8'h00, 5'd0);
    // short load: 1E, 2F, F0(last); in_valid high throughout
    addv(0, 1, 0, 8'h00, 0,   1, 0, 1, 1, 0, 1, 4'd0, 8'h00, 5'd0);
    addv(0, 0, 1, 8'h1E, 0,   1, 0, 1, 1, 0, 0, 4'd0, 8'h1E, 5'd0);
    addv(0, 0, 1, 8'hEE, 0,   0, 0, 1, 1, 0, 0, 4'd0, 8'h1E, 5'd0);
    addv(0, 0, 1, 8'hEE, 1,   1, 0, 1, 1, 0, 0, 4'd0, 8'h1E, 5'd1);
    addv(0, 0, 1, 8'hEE, 1,   1, 0, 1, 1, 0, 1, 4'd1, 8'h1E, 5'd1);
    addv(0, 0, 1, 8'h2F, 0,   1, 0, 1, 1, 0, 0, 4'd1, 8'h2F, 5'd1);
    addv(0, 0, 1, 8'hEE, 0,   0, 0, 1, 1, 0, 0, 4'd1, 8'h2F, 5'd1);
    addv(0, 0, 1, 8'hEE, 0,   1, 0, 1, 1, 0, 0, 4'd1, 8'h2F, 5'd2);
    addv(0, 0, 1, 8'hEE, 0,   1, 0, 1, 1, 0, 1, 4'd2, 8'h2F, 5'd2);
    addv(0, 0, 1, 8'hF0, 1,   1, 0, 1, 1, 0, 0, 4'd2, 8'hF0, 5'd2);
    addv(0, 0, 0, 8'h00, 0,   0, 0, 1, 1, 0, 0, 4'd2, 8'hF0, 5'd2);
    addv(0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 0, 0, 4'd2, 8'hF0, 5'd3);
    addv(0, 0, 0, 8'h00, 0,   1, 1, 1, 1, 1, 0, 4'd2, 8'hF0, 5'd3);
    addv(0, 0, 0, 8'h00, 0,   1, 1, 0, 0, 0, 0, 4'd2, 8'hF0, 5'd3);
    // second load with start pulses while busy and a 5-cycle stall before word 2
    addv(0, 1, 0, 8'h00, 0,   1, 0, 1, 1, 0, 1, 4'd0, 8'hF0, 5'd0);
    addv(0, 0, 1, 8'h11, 0,   1, 0, 1, 1, 0, 0, 4'd0, 8'h11, 5'd0);
    addv(0, 1, 0, 8'h00, 0,   0, 0, 1, 1, 0, 0, 4'd0, 8'h11, 5'd0);
    addv(0, 1, 0, 8'h00, 0,   1, 0, 1, 1, 0, 0, 4'd0, 8'h11, 5'd1);
    addv(0, 1, 0, 8'h00, 0,   1, 0, 1, 1, 0, 1, 4'd1, 8'h11, 5'd1);
    for (int i = 0; i < 5; i++)
      addv(0, 0, 0, 8'h99, 0, 1, 0, 1, 1, 0, 1, 4'd1, 8'h11, 5'd1);
    addv(0, 0, 1, 8'h22, 1,   1, 0, 1, 1, 0, 0, 4'd1, 8'h22, 5'd1);
    addv(0, 0, 0, 8'h00, 0,   0, 0, 1, 1, 0, 0, 4'd1, 8'h22, 5'd1);
    addv(0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 0, 0, 4'd1, 8'h22, 5'd2);
    addv(0, 0, 0, 8'h00, 0,   1, 1, 1, 1, 1, 0, 4'd1, 8'h22, 5'd2);
    addv(0, 0, 0, 8'h00, 0,   1, 1, 0, 0, 0, 0, 4'd1, 8'h22, 5'd2);

    #1;
    foreach (vecs[i]) begin
      clr = vecs[i].clr; start = vecs[i].start; vld = vecs[i].vld;
      dat = vecs[i].dat; last = vecs[i].last;
      step();
      chk("we_bar",  i, 32'(we_bar),  32'(vecs[i].we));
      chk("run_prg", i, 32'(rop),     32'(vecs[i].rop));
      chk("cpu_clr", i, 32'(cpu_clr), 32'(vecs[i].cpu));
      chk("busy",    i, 32'(busy),    32'(vecs[i].bsy));
      chk("done",    i, 32'(done),    32'(vecs[i].dn));
      chk("ready",   i, 32'(rdy),     32'(vecs[i].rdy));
      chk("addr",    i, 32'(addr),    32'(vecs[i].addr));
      chk("pdata",   i, 32'(pdat),    32'(vecs[i].pdat));
      chk("words",   i, 32'(ww),      32'(vecs[i].ww));
    end

    // Full memory: 16 words, in_last never set
    begin
      int n_acc = 0;
      int n_wr = 0;
      int dones = 0;
      bit finished = 0;
      bit rdy_pre;
      start = 1; vld = 0; last = 0;
      step();
      start = 0;
      for (int cyc = 0; cyc < 120 && !finished; cyc++) begin
        vld = 1; dat = 8'(n_acc); last = 0;
        rdy_pre = rdy;
        step();
        if (rdy_pre) n_acc++;
        if (!we_bar) begin
          chk("full_addr", n_wr, 32'(addr), 32'(n_wr));
          chk("full_data", n_wr, 32'(pdat), 32'(n_wr));
          n_wr++;
        end
        if (done) begin
          dones++;
          finished = 1;
        end
      end
      vld = 0;
      chk("full_done", 0, 32'(finished), 32'd1);
      chk("full_writes", 0, 32'(n_wr), 32'd16);
      chk("full_accepted", 0, 32'(n_acc), 32'd16);
      chk("full_words", 0, 32'(ww), 32'd16);
      chk("full_addr_end", 0, 32'(addr), 32'd15);
      chk("full_rop_finish", 0, 32'(rop), 32'd1);
      step();
      chk("full_idle_busy", 0, 32'(busy), 32'd0);
      chk("full_idle_done", 0, 32'(done), 32'd0);
    end

    // Reset during WRITE of word 2
    start = 1; step(); start = 0;
    vld = 1; dat = 8'h33; last = 0; step();
    vld = 0; step(); step(); step();
    chk("mid_wait_addr", 0, 32'(addr), 32'd1);
    vld = 1; dat = 8'h44; step();
    vld = 0; step();
    chk("mid_in_write", 0, 32'(we_bar), 32'd0);
    clr = 1; start = 1; vld = 1; step();
    chk("mid_we_bar", 0, 32'(we_bar), 32'd1);
    chk("mid_rop",    0, 32'(rop),    32'd1);
    chk("mid_busy",   0, 32'(busy),   32'd0);
    chk("mid_cpu",    0, 32'(cpu_clr), 32'd0);
    chk("mid_words",  0, 32'(ww),     32'd0);
    chk("mid_ready",  0, 32'(rdy),    32'd0);
    clr = 0; vld = 0; step();
    chk("mid_restart_busy", 0, 32'(busy), 32'd1);
    chk("mid_restart_rdy",  0, 32'(rdy),  32'd1);
    start = 0;

    // WRITE_PULSE=3: one word A5 with in_last
    begin
      int low_cnt = 0;
      int falls = 0;
      bit prev_we = 1;
      bit seen_done = 0;
      step(); step();
      clr3 = 0; start3 = 1; step();
      start3 = 0; vld3 = 1; dat3 = 8'hA5; last3 = 1; step();
      vld3 = 0; dat3 = 8'h00; last3 = 0;
      chk("wp3_setup_we", 0, 32'(we_bar3), 32'd1);
      chk("wp3_setup_data", 0, 32'(pdat3), 32'hA5);
      for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
        step();
        if (!we_bar3) low_cnt++;
        if (prev_we && !we_bar3) falls++;
        prev_we = we_bar3;
        if (done3) seen_done = 1;
        else begin
          chk("wp3_addr", cyc, 32'(addr3), 32'd0);
          chk("wp3_data", cyc, 32'(pdat3), 32'hA5);
        end
      end
      chk("wp3_done", 0, 32'(seen_done), 32'd1);
      chk("wp3_low_cycles", 0, 32'(low_cnt), 32'd3);
      chk("wp3_pulses", 0, 32'(falls), 32'd1);
      chk("wp3_words", 0, 32'(ww3), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
